// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter/controller: access sizes, FSM states, port ids.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Size 11 has no legal alignment, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            SZ_W:    misaligned = (lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane handling for sub-word accesses: load extract/extend and store merge into a read word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] rd,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rd[31:16] : rd[15:0];

        case (size)
            SZ_B:    load_val = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_val = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = rd;
        endcase

        merged = rd;
        if (size == SZ_B) begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_H) begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Round-robin arbiter and load/store sequencer for a single-port word memory without byte enables.
module dmem_arbiter_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_uns,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_uns,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [31:0] mem_rd
);

    logic [2:0]  state;
    logic        last;
    logic        port;
    logic        uns;
    logic        rmw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;

    logic        grant;
    logic        sel;
    logic        s_we;
    logic        s_uns;
    logic        s_bad;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    logic [31:0] load_val;
    logic [31:0] merged;
    logic        done_any;
    logic [31:0] rdata_any;

    always_comb begin
        grant   = rst_n && (state == S_IDLE) && (p0_req || p1_req);
        // Contention goes to the port that was not granted last.
        sel     = (p0_req && p1_req) ? ~last : p1_req;
        s_we    = sel ? p1_we    : p0_we;
        s_size  = sel ? p1_size  : p0_size;
        s_uns   = sel ? p1_uns   : p0_uns;
        s_addr  = sel ? p1_addr  : p0_addr;
        s_wdata = sel ? p1_wdata : p0_wdata;
        s_bad   = misaligned(s_size, s_addr[1:0]) || ((s_addr >> 2) >= MEM_WORDS);
    end

    assign p0_gnt = grant && (sel == PORT0);
    assign p1_gnt = grant && (sel == PORT1);

    dmem_lane_align u_align (
        .size     (size),
        .uns      (uns),
        .lane     (addr[1:0]),
        .rd       (mem_rd),
        .wdata    (data[15:0]),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            last  <= PORT1;
            port  <= PORT0;
            uns   <= 1'b0;
            rmw   <= 1'b0;
            size  <= SZ_B;
            addr  <= '0;
            data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (grant) begin
                    last  <= sel;
                    port  <= sel;
                    uns   <= s_uns;
                    size  <= s_size;
                    addr  <= s_addr;
                    data  <= s_wdata;
                    rmw   <= s_we && (s_size != SZ_W);
                    if (s_bad)                         state <= S_ERR;
                    else if (s_we && (s_size == SZ_W)) state <= S_WR;
                    else                               state <= S_RD;
                end
                S_RD:  state <= S_RDW;
                // The store data register is reused to hold the merged word for the write-back.
                S_RDW: if (rmw) begin
                    data  <= merged;
                    state <= S_WR;
                end else begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_ren   = (state == S_RD);
        mem_wen   = (state == S_WR);
        mem_addr  = (mem_ren || mem_wen) ? {2'b00, addr[31:2]} : '0;
        mem_wd    = mem_wen ? data : '0;
        done_any  = ((state == S_RDW) && !rmw) || (state == S_WR) || (state == S_ERR);
        rdata_any = ((state == S_RDW) && !rmw) ? load_val : '0;

        p0_done  = done_any && (port == PORT0);
        p1_done  = done_any && (port == PORT1);
        p0_err   = (state == S_ERR) && (port == PORT0);
        p1_err   = (state == S_ERR) && (port == PORT1);
        p0_rdata = (port == PORT0) ? rdata_any : '0;
        p1_rdata = (port == PORT1) ? rdata_any : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Directed bench for dmem_arbiter_ctrl with a behavioural registered-read word memory.
module tb_dmem_arbiter_ctrl;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p0_uns;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_done, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we, p1_uns;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_done, p1_err;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_wen, mem_ren;

    logic [31:0] tbmem [0:255];
    int checks;
    int errors;

    dmem_arbiter_ctrl #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) tbmem[mem_addr[7:0]] <= mem_wd;
        if (mem_ren) mem_rd <= tbmem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_on(input int p, input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_size = sz; p0_uns = u; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_size = sz; p1_uns = u; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic req_off(input int p);
        if (p == 0) p0_req = 1'b0;
        else        p1_req = 1'b0;
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? p0_gnt : p1_gnt;
    endfunction
    function automatic logic done_of(input int p);
        return (p == 0) ? p0_done : p1_done;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? p0_err : p1_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic do_load(input string tag, input int p, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] exp);
        req_on(p, 1'b0, sz, u, a, 32'h0);
        #1;
        chk({tag, " gnt"}, gnt_of(p), 1);
        tick(); req_off(p); #1;
        chk({tag, " ren"}, mem_ren, 1);
        chk({tag, " raddr"}, mem_addr, a >> 2);
        chk({tag, " early done"}, done_of(p), 0);
        tick(); #1;
        chk({tag, " done"}, done_of(p), 1);
        chk({tag, " err"}, err_of(p), 0);
        chk({tag, " rdata"}, rdata_of(p), exp);
        chk({tag, " other done"}, done_of(1 - p), 0);
        chk({tag, " other rdata"}, rdata_of(1 - p), 0);
        tick();
    endtask

    task automatic do_sw(input string tag, input int p, input logic [31:0] a, input logic [31:0] wd);
        req_on(p, 1'b1, SZ_W, 1'b0, a, wd);
        #1;
        chk({tag, " gnt"}, gnt_of(p), 1);
        tick(); req_off(p); #1;
        chk({tag, " wen"}, mem_wen, 1);
        chk({tag, " ren"}, mem_ren, 0);
        chk({tag, " waddr"}, mem_addr, a >> 2);
        chk({tag, " wd"}, mem_wd, wd);
        chk({tag, " done"}, done_of(p), 1);
        tick();
    endtask

    task automatic do_sub(input string tag, input int p, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_word);
        req_on(p, 1'b1, sz, 1'b0, a, wd);
        #1;
        chk({tag, " gnt"}, gnt_of(p), 1);
        tick(); req_off(p); #1;
        chk({tag, " ren"}, mem_ren, 1);
        chk({tag, " wen@rd"}, mem_wen, 0);
        tick(); #1;
        chk({tag, " wen@rdw"}, mem_wen, 0);
        chk({tag, " done@rdw"}, done_of(p), 0);
        tick(); #1;
        chk({tag, " wen"}, mem_wen, 1);
        chk({tag, " wd"}, mem_wd, exp_word);
        chk({tag, " done"}, done_of(p), 1);
        tick();
    endtask

    task automatic do_err(input string tag, input int p, input logic we, input logic [1:0] sz,
                          input logic [31:0] a);
        req_on(p, we, sz, 1'b0, a, 32'h1234_5678);
        #1;
        chk({tag, " gnt"}, gnt_of(p), 1);
        tick(); req_off(p); #1;
        chk({tag, " done"}, done_of(p), 1);
        chk({tag, " err"}, err_of(p), 1);
        chk({tag, " mem access"}, {mem_ren, mem_wen}, 0);
        tick(); #1;
        chk({tag, " done cleared"}, done_of(p), 0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = SZ_W; p0_uns = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = SZ_W; p1_uns = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset: a request during reset must not be granted.
        p0_req = 1'b1;
        tick(); tick(); #1;
        chk("rst gnt", p0_gnt, 0);
        chk("rst mem", {mem_ren, mem_wen, p0_done, p1_done, p0_err}, 0);
        chk("rst addr", mem_addr, 0);
        p0_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        do_sw("sw", 0, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("sw idle wen", mem_wen, 0);
        chk("sw idle done", p0_done, 0);
        chk("sw memword", tbmem[4], 32'hDEAD_BEEF);
        tick();

        do_sw("sw2", 0, 32'h10, 32'h80FF_1234);
        do_load("lb13",  0, SZ_B, 1'b0, 32'h13, 32'hFFFF_FF80);
        do_load("lbu13", 0, SZ_B, 1'b1, 32'h13, 32'h0000_0080);
        do_load("lb11",  0, SZ_B, 1'b0, 32'h11, 32'h0000_0012);
        do_load("lh12",  0, SZ_H, 1'b0, 32'h12, 32'hFFFF_80FF);
        do_load("lhu10", 0, SZ_H, 1'b1, 32'h10, 32'h0000_1234);
        do_load("lhu12", 1, SZ_H, 1'b1, 32'h12, 32'h0000_80FF);

        do_sub("sb11", 1, SZ_B, 32'h11, 32'h1234_56AA, 32'h80FF_AA34);
        do_load("lw after sb", 0, SZ_W, 1'b0, 32'h10, 32'h80FF_AA34);
        do_sub("sh12", 0, SZ_H, 32'h12, 32'h0000_BEEF, 32'hBEEF_AA34);
        do_load("lw after sh", 1, SZ_W, 1'b0, 32'h10, 32'hBEEF_AA34);

        // Top word of memory is in range; one past it is not.
        do_sw("sw top", 0, 32'h3FC, 32'h5A5A_0001);
        do_load("lw top", 1, SZ_W, 1'b0, 32'h3FC, 32'h5A5A_0001);
        do_err("lw mis", 0, 1'b0, SZ_W, 32'h12);
        do_err("lw oor", 0, 1'b0, SZ_W, 32'h400);
        do_err("size11", 1, 1'b0, 2'b11, 32'h10);
        do_err("sh odd", 0, 1'b1, SZ_H, 32'h11);

        // Simultaneous requests straight out of reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req_on(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        req_on(1, 1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0);
        #1;
        chk("arb1 p0 gnt", p0_gnt, 1);
        chk("arb1 p1 gnt", p1_gnt, 0);
        tick(); req_off(0); #1;
        chk("arb1 p1 wait rd", p1_gnt, 0);
        tick(); #1;
        chk("arb1 p0 done", p0_done, 1);
        chk("arb1 p0 rdata", p0_rdata, 32'hBEEF_AA34);
        chk("arb1 p1 wait rdw", p1_gnt, 0);
        tick(); #1;
        chk("arb1 p1 gnt later", p1_gnt, 1);
        tick(); req_off(1);
        tick(); #1;
        chk("arb1 p1 done", p1_done, 1);
        chk("arb1 p1 rdata", p1_rdata, 32'h5A5A_0001);
        tick();
        req_on(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        req_on(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        #1;
        chk("arb2 p0 gnt", p0_gnt, 1);
        chk("arb2 p1 gnt", p1_gnt, 0);
        tick(); req_off(0);
        tick();
        tick(); #1;
        chk("arb2 p1 gnt later", p1_gnt, 1);
        tick(); req_off(1);
        tick(); tick();

        // Reset during the read-wait phase of a byte store drops it.
        req_on(0, 1'b1, SZ_B, 1'b0, 32'h10, 32'h0000_0077);
        #1;
        chk("rmwrst gnt", p0_gnt, 1);
        tick(); req_off(0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rmwrst outs", {mem_ren, mem_wen, p0_done, p0_err, p1_done}, 0);
        chk("rmwrst rdata", p0_rdata, 0);
        tick(); #1;
        chk("rmwrst wen", mem_wen, 0);
        chk("rmwrst done", p0_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmwrst memword", tbmem[4], 32'hBEEF_AA34);
        do_load("post rst p1", 1, SZ_W, 1'b0, 32'h10, 32'hBEEF_AA34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
